// File: rtl/keypad_digit_display.sv
// Dual-digit seven-segment display stage: keeps the last two key codes, time-multiplexes
// them onto one shared segment bus with inter-phase anode blanking, and drives a hold LED.
module keypad_digit_display #(
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 8,
  parameter int unsigned LED_HOLD     = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [3:0] digit_lo,
  output logic [3:0] digit_hi,
  output logic       led_key
);

  localparam int unsigned CntW  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned HoldW = $clog2(LED_HOLD + 1);

  localparam logic [CntW-1:0]  CntMax   = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0]  CntBlank = CntW'(BLANK_CYCLES);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(LED_HOLD);

  localparam logic [6:0] SegOff = 7'b1111111;
  localparam logic [1:0] AnOff  = 2'b11;

  typedef enum logic {SelLo, SelHi} sel_e;

  logic [CntW-1:0]  cnt_q, cnt_d;
  sel_e             sel_q, sel_d;
  logic [3:0]       lo_q, lo_d, hi_q, hi_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             led_q, led_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = SegOff;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d  = cnt_q + CntW'(1);
    sel_d  = sel_q;
    lo_d   = lo_q;
    hi_d   = hi_q;
    hold_d = hold_q;
    seg_d  = SegOff;
    an_d   = AnOff;

    if (cnt_q == CntMax) begin
      cnt_d = '0;
      sel_d = (sel_q == SelLo) ? SelHi : SelLo;
    end

    if (key_valid) begin
      hi_d = lo_q;
      lo_d = key_code;
    end

    // A strobe reloads the full hold time rather than extending it.
    if (key_valid) begin
      hold_d = HoldLoad;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HoldW'(1);
    end
    led_d = (hold_d != '0);

    // Display is driven from this cycle's state, so a digit captured now shows next cycle.
    if (cnt_q >= CntBlank) begin
      if (sel_q == SelLo) begin
        an_d  = 2'b10;
        seg_d = hex_to_seg(lo_q);
      end else begin
        an_d  = 2'b01;
        seg_d = hex_to_seg(hi_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sel_q  <= SelLo;
      lo_q   <= 4'h0;
      hi_q   <= 4'h0;
      hold_q <= '0;
      led_q  <= 1'b0;
      seg_q  <= SegOff;
      an_q   <= AnOff;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      lo_q   <= lo_d;
      hi_q   <= hi_d;
      hold_q <= hold_d;
      led_q  <= led_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign digit_lo = lo_q;
  assign digit_hi = hi_q;
  assign led_key  = led_q;

endmodule

// File: doc/keypad_digit_display.md
Name: keypad_digit_display

Overview:
- Downstream display stage for the keypad scanner.
- Takes a one-cycle key strobe with a 4-bit hex key code, keeps the last two keys pressed, and time-multiplexes them onto a dual common-anode seven-segment display (one shared seg bus, two anode enables).
- Adds anode blanking between digit phases to kill ghosting, and drives a retriggerable "key received" LED.

Parameters:
- REFRESH_DIV, 1000, clock cycles per digit phase (each digit lit once per 2*REFRESH_DIV cycles); must be >= 2.
- BLANK_CYCLES, 8, cycles at the start of each phase with both anodes off; must be < REFRESH_DIV.
- LED_HOLD, 50000, cycles led_key stays high after the most recent key strobe; must be >= 1.

Ports:
- clk  input  1  system clock (divided scan clock domain)
- reset  input  1  synchronous, active-high reset
- key_valid  input  1  one-cycle strobe: key_code holds a newly pressed key
- key_code  input  4  hex value of pressed key (0x0-0xF)
- seg  output  7  segments {g,f,e,d,c,b,a}, active low (0 = lit)
- an  output  2  anode enables, active low; an[0] = low digit (newest), an[1] = high digit (previous)
- digit_lo  output  4  newest key value
- digit_hi  output  4  previous key value
- led_key  output  1  high while key-received hold timer is running

Behaviour:
- Everything is synchronous to clk; reset is sampled only on the rising edge.
- Reset values:
  - digit_lo = digit_hi = 0
  - phase counter cnt = 0, sel = LO
  - hold counter = 0, led_key = 0
  - seg = 7'b1111111, an = 2'b11
- Key capture: on every edge with key_valid = 1, digit_hi <= digit_lo and digit_lo <= key_code.
  - A strobe held for N cycles shifts N times; upstream guarantees single-cycle strobes.
  - key_valid is ignored while reset = 1.
- Phase counter: cnt increments each cycle.
  - When cnt == REFRESH_DIV-1, cnt <= 0 and sel toggles (LO -> HI -> LO).
  - The cycle sequence is SHOW_LO (cnt 0..REFRESH_DIV-1, sel = LO) then SHOW_HI (same range, sel = HI), repeating.
- Outputs seg and an are registered from the current-cycle state (cnt, sel, digit regs): 1-cycle latency.
  - If cnt < BLANK_CYCLES: an = 2'b11, seg = 7'b1111111.
  - Else if sel = LO: an = 2'b10, seg = hex(digit_lo).
  - Else (sel = HI): an = 2'b01, seg = hex(digit_hi).
  - an never has both bits low.
- Hex decode (seg, active low):
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000
  - 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - 8 0000000, 9 0010000, A 0001000, b 0000011
  - C 1000110, d 0100001, E 0000110, F 0001110
- led_key: a key_valid edge loads the hold counter with LED_HOLD and sets led_key = 1.
  - Otherwise the counter decrements while nonzero.
  - led_key = (counter != 0) as registered.
  - A new strobe during the hold reloads the counter to LED_HOLD (retrigger); there is no extension beyond LED_HOLD from the last strobe.
- Simultaneous key_valid and phase wrap: both take effect on the same edge. The new digit appears on the seg bus from the next cycle in which that digit is selected and unblanked.
- A key arriving mid-phase changes seg on the following cycle without blanking. This is accepted.
- Reset mid-phase: all state returns to reset values on that edge and outputs go dark on the same edge. After reset, the sequence restarts at SHOW_LO with blanking.
- digit_lo and digit_hi are direct register outputs (0-cycle latency after the capture edge).

Test Plan:
- Reset, then release with REFRESH_DIV=10, BLANK_CYCLES=2 -> edges 1-2 after release: an=11, seg=1111111. Edge 3: an=10, seg=1000000 ("0"). Edge 11: an=11 (blank, HI phase). Edge 13: an=01, seg=1000000.
- Strobe key 0x5, then 0xA, 5 cycles apart -> digit_lo=A, digit_hi=5. LO phase unblanked shows seg=0001000; HI phase shows seg=0010010.
- Strobe key 0x3 on the exact edge where cnt==REFRESH_DIV-1 -> digit_lo=3 on that edge, sel flips to HI on the same edge. The next LO unblanked phase shows 0110000; no lost or double shift.
- Run 3 full refresh periods and assert on every cycle that an != 2'b00 and that an=11 exactly in the first BLANK_CYCLES outputs of each phase.
- LED_HOLD=20: strobe at t=0 and t=10 -> led_key high from edge 1 through edge 30 and low at edge 31. With a single strobe, led_key is high for exactly 20 cycles.
- Assert reset mid-SHOW_HI with digits 7/E loaded -> next edge: an=11, seg=1111111, digits=0, led_key=0. Key strobes during reset are ignored.
